// File: rtl/alu_control_seq_if.sv
// Handshake and result bundle between the main control unit and the ALU control sequencer.
interface alu_control_seq_if #(
    parameter int OP_WIDTH = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          ALUOp;
    logic [5:0]          ALUFunction;
    logic                op_valid;
    logic [OP_WIDTH-1:0] ALUOperation;
    logic                illegal_op;
    logic                busy;
    logic                done;

    modport master (
        output in_valid, ALUOp, ALUFunction,
        input  in_ready, op_valid, ALUOperation, illegal_op, busy, done
    );

    modport slave (
        input  in_valid, ALUOp, ALUFunction,
        output in_ready, op_valid, ALUOperation, illegal_op, busy, done
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder that also sequences multi-cycle MULT/DIV with a busy countdown.
module alu_control_seq #(
    parameter int OP_WIDTH   = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    alu_control_seq_if.slave   bus
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [3:0] CODE_MULT = 4'b1101;
    localparam logic [3:0] CODE_DIV  = 4'b1110;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_WIDTH-1:0] op_q, op_d;
    logic                op_valid_q, op_valid_d;
    logic                illegal_q, illegal_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4:0]          dec_s;
    logic                accept_s;

    // Returns {illegal, code}; code is meaningful only when illegal is clear.
    function automatic logic [4:0] decode(input logic [2:0] alu_op, input logic [5:0] funct);
        logic [4:0] res;
        case (alu_op)
            3'b111: begin
                case (funct)
                    6'b100100: res = {1'b0, 4'b0000};
                    6'b100101: res = {1'b0, 4'b0001};
                    6'b100111: res = {1'b0, 4'b0010};
                    6'b100000: res = {1'b0, 4'b0011};
                    6'b100010: res = {1'b0, 4'b0100};
                    6'b100110: res = {1'b0, 4'b0101};
                    6'b000000: res = {1'b0, 4'b1000};
                    6'b000010: res = {1'b0, 4'b1001};
                    6'b101010: res = {1'b0, 4'b1010};
                    6'b000100: res = {1'b0, 4'b1011};
                    6'b000110: res = {1'b0, 4'b1100};
                    6'b011000: res = {1'b0, CODE_MULT};
                    6'b011010: res = {1'b0, CODE_DIV};
                    default:   res = {1'b1, 4'b1111};
                endcase
            end
            3'b110:  res = {1'b0, 4'b0111};
            3'b101:  res = {1'b0, 4'b0001};
            3'b100:  res = {1'b0, 4'b0011};
            3'b011:  res = {1'b0, 4'b0101};
            3'b010:  res = {1'b0, 4'b0110};
            3'b001:  res = {1'b0, 4'b0000};
            3'b000:  res = {1'b0, 4'b1010};
            default: res = {1'b1, 4'b1111};
        endcase
        return res;
    endfunction

    assign dec_s    = decode(bus.ALUOp, bus.ALUFunction);
    assign accept_s = bus.in_valid && (state_q == IDLE);

    // Next-state: accept/decode in IDLE, count down the multi-cycle op in BUSY.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        op_valid_d = 1'b0;
        illegal_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_valid_d = 1'b1;
                    illegal_d  = dec_s[4];
                    op_d       = dec_s[4] ? {OP_WIDTH{1'b1}} : OP_WIDTH'(dec_s[3:0]);
                    if (!dec_s[4] && (dec_s[3:0] == CODE_MULT)) begin
                        state_d = BUSY;
                        cnt_d   = MUL_LOAD;
                        busy_d  = 1'b1;
                        done_d  = (MUL_LOAD == {CNT_W{1'b0}});
                    end else if (!dec_s[4] && (dec_s[3:0] == CODE_DIV)) begin
                        state_d = BUSY;
                        cnt_d   = DIV_LOAD;
                        busy_d  = 1'b1;
                        done_d  = (DIV_LOAD == {CNT_W{1'b0}});
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // done is registered, so it is raised while stepping into the cnt==0 cycle.
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                    done_d = (cnt_q == CNT_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset also aborts an op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= {OP_WIDTH{1'b0}};
            op_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            illegal_q  <= illegal_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.op_valid     = op_valid_q;
    assign bus.ALUOperation = op_q;
    assign bus.illegal_op   = illegal_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized scoreboard bench for alu_control_seq against a table-driven reference model.
module tb_alu_control_seq;
    localparam int MUL_C = 4;
    localparam int DIV_C = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_control_seq_if #(.OP_WIDTH(4)) bus ();

    alu_control_seq #(.OP_WIDTH(4), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        int       e;
        bit [3:0] op;
        bit       ill;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;
    int   rst_edge  = -10;
    int   busy_lo   = -10;
    int   busy_hi   = -10;
    int   done_at   = -10;
    bit   mon_on    = 1'b0;
    bit [3:0] hold  = 4'd0;

    bit [5:0] r_funct [13] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b100110,
                               6'b000000, 6'b000010, 6'b101010, 6'b000100, 6'b000110, 6'b011000, 6'b011010};
    bit [3:0] r_code  [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    // Indexed by ALUOp 0..6
    bit [3:0] i_code  [7]  = '{4'b1010, 4'b0000, 4'b0110, 4'b0101, 4'b0011, 4'b0001, 4'b0111};

    function automatic bit busy_at(int e);
        return (e >= busy_lo) && (e <= busy_hi);
    endfunction

    task automatic ref_op(input bit [2:0] a, input bit [5:0] f, output bit [3:0] code,
                          output bit ill, output int cycles);
        code = 4'b1111;
        ill  = 1'b1;
        if (a != 3'd7) begin
            code = i_code[a];
            ill  = 1'b0;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (r_funct[i] == f) begin
                    code = r_code[i];
                    ill  = 1'b0;
                end
            end
        end
        cycles = (!ill && code == 4'd13) ? MUL_C : (!ill && code == 4'd14) ? DIV_C : 0;
    endtask

    task automatic chk(input string name, input int act, input int expv);
        total_cnt++;
        if (act != expv) $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, expv);
        else pass_cnt++;
    endtask

    task automatic step(input bit r, input bit v, input bit [2:0] a, input bit [5:0] f);
        bit [3:0] code;
        bit       ill;
        int       cycles;
        int       k;
        exp_t     ent;
        reset           = r;
        bus.in_valid    = v;
        bus.ALUOp       = a;
        bus.ALUFunction = f;
        @(posedge clk);
        cyc = cyc + 1;
        k   = cyc;
        if (r) begin
            if (busy_hi >= k) busy_hi = k - 1;
            if (done_at >= k) done_at = -10;
            exp_q.delete();
            rst_edge = k;
        end else if (v && !busy_at(k - 1)) begin
            ref_op(a, f, code, ill, cycles);
            ent.e = k; ent.op = code; ent.ill = ill;
            exp_q.push_back(ent);
            if (cycles > 0) begin
                busy_lo = k;
                busy_hi = k + cycles - 1;
                done_at = busy_hi;
            end
        end
        mon_on = 1'b1;
        #1;
    endtask

    // Monitor: per-cycle status checks plus scoreboard pop on op_valid.
    always @(negedge clk) begin
        if (mon_on) begin
            bit   exp_v;
            exp_t ent;
            if (rst_edge == cyc) hold = 4'd0;
            chk("busy", int'(bus.busy), int'(busy_at(cyc)));
            chk("in_ready", int'(bus.in_ready), int'(!busy_at(cyc)));
            chk("done", int'(bus.done), int'(done_at == cyc));
            exp_v = (exp_q.size() > 0) && (exp_q[0].e == cyc);
            chk("op_valid", int'(bus.op_valid), int'(exp_v));
            if (exp_v) begin
                ent  = exp_q.pop_front();
                hold = ent.op;
                chk("ALUOperation", int'(bus.ALUOperation), int'(ent.op));
                chk("illegal_op", int'(bus.illegal_op), int'(ent.ill));
            end else begin
                chk("ALUOperation_hold", int'(bus.ALUOperation), int'(hold));
                chk("illegal_idle", int'(bus.illegal_op), 0);
            end
        end
    end

    initial begin
        bit       r, v;
        bit [2:0] a;
        bit [5:0] f;
        reset = 1'b1; bus.in_valid = 1'b0; bus.ALUOp = 3'd0; bus.ALUFunction = 6'd0;
        // T1 reset with in_valid high
        step(1'b1, 1'b1, 3'd7, 6'b100000);
        step(1'b1, 1'b1, 3'd7, 6'b100000);
        // T2 ADD
        step(1'b0, 1'b1, 3'd7, 6'b100000);
        step(1'b0, 1'b0, 3'd0, 6'd0);
        // T3 MULT, then ADD pushed during busy
        step(1'b0, 1'b1, 3'd7, 6'b011000);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 3'd7, 6'b100000);
        // T4 illegal, then ANDI
        step(1'b0, 1'b1, 3'd7, 6'b111111);
        step(1'b0, 1'b1, 3'd1, 6'b101010);
        step(1'b0, 1'b0, 3'd0, 6'd0);
        // T5 DIV aborted by reset at the 10th busy cycle
        step(1'b0, 1'b1, 3'd7, 6'b011010);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 3'd4, 6'd0);
        step(1'b1, 1'b0, 3'd0, 6'd0);
        step(1'b0, 1'b0, 3'd0, 6'd0);
        // T6 back-to-back I-type classes
        step(1'b0, 1'b1, 3'd2, 6'd0);
        step(1'b0, 1'b1, 3'd3, 6'd0);
        step(1'b0, 1'b1, 3'd6, 6'd0);
        step(1'b0, 1'b1, 3'd5, 6'd0);
        step(1'b0, 1'b0, 3'd0, 6'd0);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 79) == 0);
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            f = ($urandom_range(0, 9) < 7) ? r_funct[$urandom_range(0, 12)] : 6'($urandom_range(0, 63));
            step(r, v, a, f);
        end
        step(1'b0, 1'b0, 3'd0, 6'd0);
        step(1'b0, 1'b0, 3'd0, 6'd0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
